// File: rtl/logic_unit_pipe.sv
// Purpose: pipelined eight-way bitwise logic unit with zero/all-ones/parity flags.
// Latency: STAGES edges from the accepting edge; result visible in the cycle after edge N+STAGES-1.
// Backpressure: global stall when out_valid && !out_ready; every stage holds and in_ready drops.
//
// Ports:
//   clock, clear      - core clock, asynchronous active-low reset
//   in_valid/in_ready - operand handshake; op, Ra, Rb sampled on accept
//   out_valid/out_ready - result handshake; Rz and flags straight from last stage
//   Rz, flag_zero, flag_ones, flag_parity - result and its flags
module logic_unit_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] Ra,
  input  logic [WIDTH-1:0] Rb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Rz,
  output logic             flag_zero,
  output logic             flag_ones,
  output logic             flag_parity
);

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             ones;
    logic             par;
  } stage_t;

  // A cleared stage looks like a zero result: flag_zero set, others clear.
  localparam stage_t STAGE_RST = '{vld: 1'b0, res: '0, zero: 1'b1, ones: 1'b0, par: 1'b0};

  stage_t           stage_q [STAGES];
  stage_t           stage_d;
  logic [WIDTH-1:0] fn_res;
  logic             stall;

  assign stall    = stage_q[STAGES-1].vld && !out_ready;
  assign in_ready = !stall;

  // Function and flags are formed before stage 1 so each stage carries both.
  always_comb begin
    fn_res = '0;
    case (op)
      3'd0: fn_res = Ra & Rb;
      3'd1: fn_res = Ra | Rb;
      3'd2: fn_res = Ra ^ Rb;
      3'd3: fn_res = ~(Ra & Rb);
      3'd4: fn_res = ~(Ra | Rb);
      3'd5: fn_res = ~(Ra ^ Rb);
      3'd6: fn_res = ~Ra;
      3'd7: fn_res = Ra & ~Rb;
      default: fn_res = '0;
    endcase
    stage_d.vld  = in_valid && in_ready;
    stage_d.res  = fn_res;
    stage_d.zero = (fn_res == '0);
    stage_d.ones = &fn_res;
    stage_d.par  = ^fn_res;
  end

  // Whole pipe moves as one: either every stage shifts or every stage holds.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= STAGE_RST;
      end
    end else if (!stall) begin
      stage_q[0] <= stage_d;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign out_valid   = stage_q[STAGES-1].vld;
  assign Rz          = stage_q[STAGES-1].res;
  assign flag_zero   = stage_q[STAGES-1].zero;
  assign flag_ones   = stage_q[STAGES-1].ones;
  assign flag_parity = stage_q[STAGES-1].par;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: WIDTH=32/STAGES=2 main instance under a scoreboard,
// plus WIDTH=8 instances at STAGES=1 and STAGES=4 for latency corners.
module tb_logic_unit_pipe;

  logic        clock = 1'b0;
  logic        clear;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  op;
  logic [31:0] Ra, Rb, Rz;
  logic        flag_zero, flag_ones, flag_parity;

  logic        v8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8;
  logic        u1_in_rdy, u1_vld, u1_z, u1_o, u1_p;
  logic        u4_in_rdy, u4_vld, u4_z, u4_o, u4_p;
  logic [7:0]  u1_rz, u4_rz;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int pops     = 0;

  logic [31:0] sbq[$];
  int          accq[$];
  logic        prev_stall;
  logic [31:0] prev_rz;

  always #5 clock = ~clock;

  logic_unit_pipe #(.WIDTH(32), .STAGES(2)) dut (
    .clock(clock), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .Ra(Ra), .Rb(Rb), .out_valid(out_valid), .out_ready(out_ready),
    .Rz(Rz), .flag_zero(flag_zero), .flag_ones(flag_ones), .flag_parity(flag_parity)
  );

  logic_unit_pipe #(.WIDTH(8), .STAGES(1)) u_s1 (
    .clock(clock), .clear(clear), .in_valid(v8), .in_ready(u1_in_rdy),
    .op(op8), .Ra(a8), .Rb(b8), .out_valid(u1_vld), .out_ready(1'b1),
    .Rz(u1_rz), .flag_zero(u1_z), .flag_ones(u1_o), .flag_parity(u1_p)
  );

  logic_unit_pipe #(.WIDTH(8), .STAGES(4)) u_s4 (
    .clock(clock), .clear(clear), .in_valid(v8), .in_ready(u4_in_rdy),
    .op(op8), .Ra(a8), .Rb(b8), .out_valid(u4_vld), .out_ready(1'b1),
    .Rz(u4_rz), .flag_zero(u4_z), .flag_ones(u4_o), .flag_parity(u4_p)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour straight from the operation table.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return ~(a ^ b);
      3'd6: return ~a;
      default: return a & ~b;
    endcase
  endfunction

  // Scoreboard for the main instance, sampled mid-cycle.
  always @(negedge clock) begin
    logic [31:0] e;
    int          a;
    cyc++;
    if (!clear) begin
      sbq.delete();
      accq.delete();
      prev_stall = 1'b0;
    end else begin
      chk("in_ready_vs_stall", in_ready, !(out_valid && !out_ready));
      if (prev_stall) begin
        chk("stall_hold_valid", out_valid, 1);
        chk("stall_hold_rz", Rz, prev_rz);
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("spurious_out_valid", 1, 0);
        end else begin
          e = sbq.pop_front();
          a = accq.pop_front();
          pops++;
          chk("sb_rz", Rz, e);
          chk("sb_zero", flag_zero, e == 32'h0);
          chk("sb_ones", flag_ones, e == 32'hFFFF_FFFF);
          chk("sb_parity", flag_parity, ^e);
          chk("sb_min_latency", (cyc - a) >= 2, 1);
        end
      end
      if (in_valid && in_ready) begin
        sbq.push_back(model(op, Ra, Rb));
        accq.push_back(cyc);
      end
      prev_stall = out_valid && !out_ready;
      prev_rz    = Rz;
    end
  end

  // Single op on the main instance with literal expectations; entered and left at posedge+1.
  task automatic run_one(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input logic ez, input logic eo, input logic ep);
    int n;
    op = o; Ra = a; Rb = b; in_valid = 1'b1;
    @(posedge clock); #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    chk("one_latency", n, 1);
    chk("one_rz", Rz, exp);
    chk("one_zero", flag_zero, ez);
    chk("one_ones", flag_ones, eo);
    chk("one_parity", flag_parity, ep);
  endtask

  logic [31:0] seq_exp [8] = '{32'h0000_00FF, 32'h00FF_FFFF, 32'h00FF_FF00, 32'hFFFF_FF00,
                               32'hFF00_0000, 32'hFF00_00FF, 32'hFFFF_0000, 32'h0000_FF00};

  initial begin
    int n;
    int pops0;
    logic [31:0] hold;
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = 3'd0; Ra = '0; Rb = '0;
    v8 = 1'b0; op8 = 3'd0; a8 = '0; b8 = '0;
    prev_stall = 1'b0; prev_rz = '0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_rz", Rz, 0);
    chk("rst_zero", flag_zero, 1);
    chk("rst_ones", flag_ones, 0);
    chk("rst_parity", flag_parity, 0);
    chk("rst_in_ready", in_ready, 1);
    clear = 1'b1;
    @(posedge clock); #1;

    // Basic AND
    run_one(3'd0, 32'hFFFF_FFFF, 32'hFFFF_0000, 32'hFFFF_0000, 0, 0, 0);
    @(posedge clock); #1;
    chk("basic_drained", out_valid, 0);

    // All eight ops back to back
    op = 3'd0; Ra = 32'h0000_FFFF; Rb = 32'h00FF_00FF; in_valid = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(posedge clock); #1;
      if (k + 1 < 8) op = 3'(k + 1);
      else in_valid = 1'b0;
      if (k >= 1) begin
        chk("seq_valid", out_valid, 1);
        chk("seq_rz", Rz, seq_exp[k-1]);
      end
    end
    @(posedge clock); #1;

    // Flags
    run_one(3'd0, 32'h0, 32'hFFFF_FFFF, 32'h0, 1, 0, 0);
    run_one(3'd5, 32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFF, 0, 1, 0);
    run_one(3'd2, 32'h1, 32'h0, 32'h1, 0, 0, 1);
    repeat (2) @(posedge clock); #1;

    // Backpressure: four ops, 3-cycle stall once the first result appears
    pops0 = pops;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          int w;
          op = 3'(i + 1); Ra = 32'hA5A5_0000 + 32'(i); Rb = 32'h0F0F_F0F0 ^ 32'(i * 3);
          in_valid = 1'b1;
          @(negedge clock);
          w = 0;
          while (!in_ready && w < 20) begin
            @(negedge clock);
            w++;
          end
          @(posedge clock); #1;
        end
        in_valid = 1'b0;
      end
      begin
        n = 0;
        while (!out_valid && n < 20) begin
          @(posedge clock); #1;
          n++;
        end
        chk("bp_first_seen", out_valid, 1);
        hold = Rz;
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clock);
          chk("bp_in_ready_low", in_ready, 0);
          chk("bp_rz_stable", Rz, hold);
          @(posedge clock); #1;
        end
        out_ready = 1'b1;
      end
    join
    n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    @(posedge clock); #1;
    chk("bp_result_count", pops - pops0, 4);
    chk("bp_idle", out_valid, 0);

    // Reset with two results in flight
    op = 3'd1; Ra = 32'h1111_0000; Rb = 32'h0000_2222; in_valid = 1'b1;
    @(posedge clock); #1;
    op = 3'd2; Ra = 32'h3333_3333; Rb = 32'h0;
    @(posedge clock); #1;
    in_valid = 1'b0;
    chk("rstmid_pre_valid", out_valid, 1);
    #2 clear = 1'b0;
    #1;
    chk("rstmid_out_valid", out_valid, 0);
    chk("rstmid_rz", Rz, 0);
    chk("rstmid_zero", flag_zero, 1);
    chk("rstmid_in_ready", in_ready, 1);
    #3 clear = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      chk("rstmid_no_stale", out_valid, 0);
    end
    chk("rstmid_sb_empty", sbq.size(), 0);
    run_one(3'd4, 32'h0, 32'h0, 32'hFFFF_FFFF, 0, 1, 0);
    @(posedge clock); #1;

    // WIDTH=8: STAGES=1 and STAGES=4 latency corners
    op8 = 3'd6; a8 = 8'hA5; b8 = 8'h00; v8 = 1'b1;
    @(posedge clock); #1;
    op8 = 3'd7; a8 = 8'hF0; b8 = 8'h3C;
    chk("s1_valid", u1_vld, 1);
    chk("s1_rz", u1_rz, 8'h5A);
    chk("s1_parity", u1_p, 0);
    chk("s4_not_yet", u4_vld, 0);
    @(posedge clock); #1;
    v8 = 1'b0;
    chk("s1_andn_rz", u1_rz, 8'hC0);
    chk("s1_andn_zero", u1_z, 0);
    n = 1;
    while (!u4_vld && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    chk("s4_latency_edges", n, 3);
    chk("s4_rz", u4_rz, 8'h5A);
    chk("s4_ones", u4_o, 0);
    chk("s1_drained", u1_vld, 0);
    @(posedge clock); #1;
    chk("s4_second_rz", u4_rz, 8'hC0);
    @(posedge clock); #1;
    chk("s4_drained", u4_vld, 0);

    repeat (3) @(posedge clock);
    #1;
    chk("final_sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
